// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_e;

   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

   localparam logic MODE_RR    = 1'b0;
   localparam logic MODE_FIXED = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports plus the shared single-port memory bus.
interface dmem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              a_valid;
   logic              a_write;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_wdata;
   logic              a_ready;
   logic              a_resp;
   logic [DATA_W-1:0] a_rdata;

   logic              b_valid;
   logic              b_write;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] b_wdata;
   logic              b_ready;
   logic              b_resp;
   logic [DATA_W-1:0] b_rdata;

   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_writeData;
   logic              mem_memWrite;
   logic              mem_memRead;
   logic [DATA_W-1:0] mem_readData;

   // The arbiter side: serves both requesters and owns the memory bus.
   modport slave (
      input  a_valid, a_write, a_addr, a_wdata,
      output a_ready, a_resp, a_rdata,
      input  b_valid, b_write, b_addr, b_wdata,
      output b_ready, b_resp, b_rdata,
      output mem_address, mem_writeData, mem_memWrite, mem_memRead,
      input  mem_readData
   );

   modport master (
      output a_valid, a_write, a_addr, a_wdata,
      input  a_ready, a_resp, a_rdata,
      output b_valid, b_write, b_addr, b_wdata,
      input  b_ready, b_resp, b_rdata,
      input  mem_address, mem_writeData, mem_memWrite, mem_memRead,
      output mem_readData
   );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-requester arbiter: round-robin on the last-grant pointer, or fixed priority to port A.
module rr_arb2
   import dmem_arb_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic       last_i,
   input  logic       mode_i,
   output logic [1:0] gnt_o
);

   always_comb begin
      gnt_o = 2'b00;
      case (req_i)
         2'b01: gnt_o = 2'b01;
         2'b10: gnt_o = 2'b10;
         2'b11: begin
            if (mode_i == MODE_FIXED || last_i == PORT_B) gnt_o = 2'b01;
            else                                          gnt_o = 2'b10;
         end
         default: gnt_o = 2'b00;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates CPU (a) and DMA/debug (b) requests onto one single-port data memory.
// Define DMEM_ARB_FIXED_PRIO_EN to give port a fixed priority instead of round-robin.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic          CLK,
   input  logic          RST_N,
   dmem_arbiter_if.slave bus
);

`ifdef DMEM_ARB_FIXED_PRIO_EN
   localparam logic ARB_MODE = MODE_FIXED;
`else
   localparam logic ARB_MODE = MODE_RR;
`endif

   state_e            state_q, state_d;
   logic              winner_q, winner_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              last_q, last_d;
   logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
   logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

   logic [1:0] req;
   logic [1:0] gnt;
   logic       accept;

   assign req = {bus.b_valid, bus.a_valid};

   rr_arb2 u_arb (
      .req_i  (req),
      .last_i (last_q),
      .mode_i (ARB_MODE),
      .gnt_o  (gnt)
   );

   // Gating on RST_N keeps ready low for the whole reset window, not just after the first edge.
   assign accept = (state_q == IDLE) && RST_N && (gnt != 2'b00);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (!RST_N) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = ACCESS;
         ACCESS:  state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      // NOTE: every output gets a default first so no path through the block infers a latch.
      bus.a_ready       = accept && gnt[PORT_A];
      bus.b_ready       = accept && gnt[PORT_B];
      bus.mem_address   = addr_q;
      bus.mem_writeData = wdata_q;
      bus.mem_memWrite  = (state_q == ACCESS) && wr_q;
      bus.mem_memRead   = (state_q == ACCESS) && !wr_q;
      bus.a_resp        = (state_q == RESP) && RST_N && (winner_q == PORT_A);
      bus.b_resp        = (state_q == RESP) && RST_N && (winner_q == PORT_B);
      bus.a_rdata       = a_rdata_q;
      bus.b_rdata       = b_rdata_q;
   end

   always_comb begin
      winner_d  = winner_q;
      wr_d      = wr_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      last_d    = last_q;
      a_rdata_d = a_rdata_q;
      b_rdata_d = b_rdata_q;
      if (accept) begin
         winner_d = gnt[PORT_B] ? PORT_B : PORT_A;
         wr_d     = gnt[PORT_B] ? bus.b_write : bus.a_write;
         addr_d   = gnt[PORT_B] ? bus.b_addr  : bus.a_addr;
         wdata_d  = gnt[PORT_B] ? bus.b_wdata : bus.a_wdata;
         last_d   = winner_d;
      end
      // Read data is sampled on the edge that closes the memory access cycle.
      if (state_q == ACCESS && !wr_q) begin
         if (winner_q == PORT_A) a_rdata_d = bus.mem_readData;
         else                    b_rdata_d = bus.mem_readData;
      end
   end

   // NOTE: the read-data holding registers are reset explicitly; they are visible outputs, not scratch storage.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         winner_q  <= PORT_A;
         wr_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         last_q    <= PORT_B;
         a_rdata_q <= '0;
         b_rdata_q <= '0;
      end else begin
         winner_q  <= winner_d;
         wr_q      <= wr_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         last_q    <= last_d;
         a_rdata_q <= a_rdata_d;
         b_rdata_q <= b_rdata_d;
      end
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL use parameter ADDR_W, default 32, meaning request/memory address width.
REQ-002 The block SHALL use parameter DATA_W, default 32, meaning request/memory data width.
REQ-003 The block SHALL have port CLK  in  1  the single clock; all state updates on posedge.
REQ-004 The block SHALL have port RST_N  in  1  reset, synchronous, active-low.
REQ-005 The block SHALL have ports a_valid/b_valid  in  1  request valid (a = CPU load/store port, b = DMA/debug port).
REQ-006 The block SHALL have ports a_write/b_write  in  1  request is a write when 1, a read when 0.
REQ-007 The block SHALL have ports a_addr/b_addr  in  ADDR_W  and a_wdata/b_wdata  in  DATA_W  request address and write data.
REQ-008 The block SHALL have ports a_ready/b_ready  out  1  request accepted this cycle.
REQ-009 The block SHALL have ports a_resp/b_resp  out  1  one-cycle completion pulse, and a_rdata/b_rdata  out  DATA_W  read data.
REQ-010 The block SHALL have ports mem_address  out  ADDR_W, mem_writeData  out  DATA_W, mem_memWrite  out  1, mem_memRead  out  1, mem_readData  in  DATA_W, for the shared single-port data memory.

Function
REQ-011 The FSM SHALL have states IDLE, ACCESS, RESP; transitions IDLE->ACCESS on any accepted request, ACCESS->RESP always, RESP->IDLE always.
REQ-012 a_ready/b_ready SHALL be combinational, asserted only in IDLE, for at most one port, and only when that port's valid is 1.
REQ-013 On acceptance, the block SHALL latch winner index, write flag, address and wdata; requesters SHALL hold valid and payload stable until ready.
REQ-014 With both valid in IDLE (round-robin mode), the grant SHALL go to the port not granted last; last-grant pointer resets to b so a wins first.
REQ-015 In ACCESS, mem_address/mem_writeData SHALL drive the latched values; mem_memWrite=1 for writes, mem_memRead=1 for reads, both 0 in all other states.
REQ-016 For reads, the block SHALL capture mem_readData at the posedge ending ACCESS into the winner's rdata register.
REQ-017 In RESP, the winner's resp SHALL be 1 for exactly one cycle for both reads and writes; the loser's resp SHALL stay 0.
REQ-018 Latency SHALL be: accept cycle N, memory access cycle N+1, resp and valid rdata cycle N+2; throughput one transaction per 3 cycles.
REQ-019 a_rdata/b_rdata SHALL hold their last read value until the next read completes on the same port; writes SHALL not alter them.
REQ-020 A port with valid=0 SHALL never be granted; the pointer SHALL update only on acceptance.
REQ-021 Address values SHALL pass through unmodified; out-of-range handling belongs to the memory.

Reset
REQ-022 With RST_N=0 at a posedge, state SHALL become IDLE, pointer = b, all rdata = 0, resp = 0, latched request cleared.
REQ-023 A reset asserted in ACCESS or RESP SHALL abort the transaction: no resp pulse; mem_memWrite/mem_memRead SHALL be 0 from the cycle after reset.
REQ-024 While RST_N=0, a_ready and b_ready SHALL be 0.

Configuration
REQ-025 With macro DMEM_ARB_FIXED_PRIO_EN defined, port a SHALL always win simultaneous requests and the pointer SHALL be unused.
REQ-026 Without DMEM_ARB_FIXED_PRIO_EN, the round-robin arbitration of REQ-014 SHALL apply.

Structure
REQ-027 Package dmem_arb_pkg SHALL hold the FSM state typedef (IDLE/ACCESS/RESP) and port index constants PORT_A=0, PORT_B=1.
REQ-028 Arbitration SHALL live in one sub-module rr_arb2 (inputs req[1:0], last pointer, mode; output one-hot grant), instantiated once.

Verification
REQ-029 a read addr 5 only, mem_readData=0x1234 -> a_ready cycle N, mem_memRead=1 cycle N+1, a_resp=1 and a_rdata=0x1234 cycle N+2.
REQ-030 b write addr 7 data 0xDEADBEEF -> mem_memWrite=1, mem_address=7, mem_writeData=0xDEADBEEF in ACCESS; b_resp pulse; b_rdata unchanged.
REQ-031 a and b valid continuously after reset, round-robin -> grants a,b,a,b each 3 cycles apart; fixed-prio build -> a,a,a.
REQ-032 RST_N=0 during ACCESS of an a write -> no a_resp, FSM IDLE, all outputs at reset values next cycle.
REQ-033 b valid held while a transaction in progress -> b_ready=0 until IDLE, then b granted with its original payload.
